// File: rtl/sine_dds_multi.sv
// Multi-channel DDS sine generator: per-channel phase accumulators share one
// quarter-wave table and a 4-stage pipeline.
module sine_dds_multi #(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 8,
    parameter int OUT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_ch,
    input  logic [1:0]                cfg_sel,
    input  logic [PHASE_W-1:0]        cfg_data,
    output logic [31:0]               cnt,
    output logic [CHANNELS-1:0]       cnt_edge,
    output logic [CHANNELS*OUT_W-1:0] sin_val,
    output logic                      out_valid
);

    // out_valid is a one-cycle strobe with no backpressure: sin_val and cnt_edge
    // are meaningful only while it is high; sin_val then holds until the next one.

    localparam int LUT_N = 1 << LUT_AW;
    localparam int PA_W  = LUT_AW + 2;
    localparam int PROD_W = OUT_W + 17;
    localparam logic [15:0] AMP_UNITY = 16'h8000;

    // Integer Taylor series in Q60 so the table is built without real arithmetic.
    function automatic logic [OUT_W-1:0] lut_entry(input int k);
        logic signed [127:0] pi_q60, x, term, sum, div, scale, half;
        pi_q60 = 128'sd3622009729038561421;
        x      = (pi_q60 * 128'(2 * k + 1)) >>> (LUT_AW + 2);
        term   = x;
        sum    = x;
        for (int n = 1; n <= 12; n++) begin
            div  = 128'(2 * n * (2 * n + 1));
            term = (((term * x) >>> 60) * x) >>> 60;
            term = -term / div;
            sum  = sum + term;
        end
        scale = 128'((1 << (OUT_W - 1)) - 1);
        half  = 128'sd1 <<< 59;
        sum   = (sum * scale + half) >>> 60;
        return sum[OUT_W-1:0];
    endfunction

    logic [OUT_W-1:0] lut [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam logic [OUT_W-1:0] ENTRY = lut_entry(g);
        assign lut[g] = ENTRY;
    end

    logic [PHASE_W-1:0] freq   [CHANNELS];
    logic [PHASE_W-1:0] offset [CHANNELS];
    logic [PHASE_W-1:0] acc    [CHANNELS];
    logic [15:0]        amp    [CHANNELS];

    logic               s0_valid, s1_valid, s2_valid;
    logic [PA_W-1:0]    s0_pa  [CHANNELS];
    logic [OUT_W-1:0]   s1_mag [CHANNELS];
    logic [OUT_W-1:0]   s2_smp [CHANNELS];
    logic [CHANNELS-1:0] s0_wrap, s1_wrap, s2_wrap, s1_neg;

    logic [PHASE_W:0]    acc_sum [CHANNELS];
    logic [LUT_AW-1:0]   lut_idx [CHANNELS];
    logic [OUT_W-1:0]    scaled  [CHANNELS];
    logic [CHANNELS-1:0] cfg_hit;
    logic [CHANNELS-1:0] clr_hit;
    logic [15:0]         amp_wr;

    always_comb begin
        cfg_hit = '0;
        clr_hit = '0;
        amp_wr  = (cfg_data[15:0] > AMP_UNITY) ? AMP_UNITY : cfg_data[15:0];
        for (int k = 0; k < CHANNELS; k++) begin
            cfg_hit[k] = cfg_we && (cfg_ch == 3'(k));
            clr_hit[k] = cfg_hit[k] && (cfg_sel == 2'd3);
            acc_sum[k] = {1'b0, acc[k]} + {1'b0, freq[k]};
            // Odd quadrants walk the table backwards.
            lut_idx[k] = s0_pa[k][PA_W-2] ? ~s0_pa[k][LUT_AW-1:0] : s0_pa[k][LUT_AW-1:0];
            // Product fits in PROD_W bits, so modular multiply of the sign-extended
            // sample gives the exact signed product; bits above 15 are floor(p/2^15).
            scaled[k]  = OUT_W'(({{17{s2_smp[k][OUT_W-1]}}, s2_smp[k]}
                                 * {{(PROD_W-16){1'b0}}, amp[k]}) >> 15);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            cnt_edge  <= '0;
            sin_val   <= '0;
            out_valid <= 1'b0;
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s0_wrap   <= '0;
            s1_wrap   <= '0;
            s2_wrap   <= '0;
            s1_neg    <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                freq[k]   <= '0;
                offset[k] <= '0;
                acc[k]    <= '0;
                amp[k]    <= AMP_UNITY;
                s0_pa[k]  <= '0;
                s1_mag[k] <= '0;
                s2_smp[k] <= '0;
            end
        end else begin
            if (ce) begin
                cnt <= cnt + 32'd1;
            end
            s0_valid  <= ce;
            s1_valid  <= s0_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            s1_wrap   <= s0_wrap;
            s2_wrap   <= s1_wrap;
            cnt_edge  <= s2_valid ? s2_wrap : '0;
            for (int k = 0; k < CHANNELS; k++) begin
                s0_pa[k]   <= PA_W'((acc[k] + offset[k]) >> (PHASE_W - PA_W));
                s0_wrap[k] <= ce && acc_sum[k][PHASE_W] && !clr_hit[k];
                s1_mag[k]  <= lut[lut_idx[k]];
                s1_neg[k]  <= s0_pa[k][PA_W-1];
                s2_smp[k]  <= s1_neg[k] ? -s1_mag[k] : s1_mag[k];
                if (s2_valid) begin
                    sin_val[k*OUT_W +: OUT_W] <= scaled[k];
                end
                // A clear beats a coincident tick; the tick already sampled the old acc.
                if (clr_hit[k]) begin
                    acc[k] <= '0;
                end else if (ce) begin
                    acc[k] <= acc_sum[k][PHASE_W-1:0];
                end
                if (cfg_hit[k]) begin
                    case (cfg_sel)
                        2'd0:    freq[k]   <= cfg_data;
                        2'd1:    offset[k] <= cfg_data;
                        2'd2:    amp[k]    <= amp_wr;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_dds_multi.sv
// Directed bench for sine_dds_multi (2 channels, 32-bit phase, 8-bit table, 16-bit out).
module tb_sine_dds_multi;

    logic        clk = 1'b0;
    logic        reset, ce, cfg_we;
    logic [2:0]  cfg_ch;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_data;
    logic [31:0] cnt;
    logic [1:0]  cnt_edge;
    logic [31:0] sin_val;
    logic        out_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    sine_dds_multi #(
        .CHANNELS(2), .PHASE_W(32), .LUT_AW(8), .OUT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cnt(cnt), .cnt_edge(cnt_edge),
        .sin_val(sin_val), .out_valid(out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [1:0] sel, input logic [31:0] data);
        cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One ce tick (optionally with a coincident config write), then wait for out_valid.
    task automatic tick_sample(input logic we, input logic [2:0] ch, input logic [1:0] sel,
                               input logic [31:0] data, output logic signed [15:0] s0,
                               output logic signed [15:0] s1, output logic [1:0] e);
        int lat;
        ce = 1'b1; cfg_we = we; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
        @(negedge clk);
        ce = 1'b0; cfg_we = 1'b0;
        exp_cnt++;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
        check("cnt", cnt, exp_cnt);
        s0 = sin_val[15:0];
        s1 = sin_val[31:16];
        e  = cnt_edge;
    endtask

    task automatic expect_tick(input string tag, input logic we, input logic [2:0] ch,
                               input logic [1:0] sel, input logic [31:0] data,
                               input int e0, input int e1, input int ee);
        logic signed [15:0] s0, s1, h;
        logic [1:0] e;
        tick_sample(we, ch, sel, data, s0, s1, e);
        check({tag, " ch0"}, s0, e0);
        check({tag, " ch1"}, s1, e1);
        check({tag, " edge"}, e, ee);
        @(negedge clk);
        h = sin_val[15:0];
        check({tag, " pulse"}, out_valid, 0);
        check({tag, " hold"}, h, e0);
        check({tag, " edge idle"}, cnt_edge, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic signed [15:0] smp [0:599];
        int nv, n_edge0, n_edge1, first_edge, maxv, minv, nvr;
        logic [15:0] ev;

        // Clock/reset: reset held with ce high must keep everything at zero.
        reset = 1'b1; ce = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset cnt", cnt, 0);
            check("reset valid", out_valid, 0);
            check("reset sin", sin_val, 0);
            check("reset edge", cnt_edge, 0);
        end
        reset = 1'b0; ce = 1'b0;
        @(negedge clk);
        expect_tick("first", 0, 0, 0, 0, 101, 101, 0);

        // Quadrant symmetry with freq = 0.
        cfg_write(0, 1, 32'h4000_0000); cfg_write(1, 1, 32'hC000_0000);
        expect_tick("quad a", 0, 0, 0, 0, 32767, -32767, 0);
        cfg_write(0, 1, 32'h8000_0000); cfg_write(1, 1, 32'h0000_0000);
        expect_tick("quad b", 0, 0, 0, 0, -101, 101, 0);
        cfg_write(0, 1, 32'hC000_0000); cfg_write(1, 1, 32'h4000_0000);
        expect_tick("quad c", 0, 0, 0, 0, -32767, 32767, 0);

        // Amplitude: half scale floors toward -inf, zero, clamp of 0xFFFF.
        cfg_write(0, 1, 32'h4000_0000); cfg_write(0, 2, 32'h0000_4000);
        cfg_write(1, 1, 32'hC000_0000); cfg_write(1, 2, 32'h0000_4000);
        expect_tick("amp half", 0, 0, 0, 0, 16383, -16384, 0);
        cfg_write(0, 2, 32'h0000_0000); cfg_write(1, 2, 32'h0000_FFFF);
        expect_tick("amp zero", 0, 0, 0, 0, 0, -32767, 0);
        cfg_write(0, 2, 32'h0000_FFFF);
        expect_tick("amp clamp", 0, 0, 0, 0, 32767, -32767, 0);

        // Config timing: freq write on tick 1, clear on tick 5, natural wrap on tick 9.
        cfg_write(0, 1, 32'h0); cfg_write(1, 1, 32'h0); cfg_write(1, 2, 32'h0000_2000);
        foreach (ev_tbl[i]) exp_q.push_back(ev_tbl[i]);
        for (int t = 1; t <= 10; t++) begin
            ev = exp_q.pop_front();
            expect_tick($sformatf("cfg tick %0d", t), (t == 1) || (t == 5), 0,
                        (t == 1) ? 2'd0 : 2'd3, (t == 1) ? 32'h4000_0000 : 32'h0,
                        int'($signed(ev)), 25, (t == 9) ? 1 : 0);
        end
        cfg_write(2, 3, 32'h0); cfg_write(2, 1, 32'h8000_0000);
        cfg_write(2, 2, 32'h0); cfg_write(2, 0, 32'h1234_5678);
        expect_tick("bad ch", 0, 0, 0, 0, 32767, 25, 0);

        // Continuous ce with freq 2^24: 256-sample period.
        cfg_write(0, 0, 32'h0100_0000); cfg_write(0, 3, 32'h0);
        nv = 0; n_edge0 = 0; n_edge1 = 0; first_edge = -1; maxv = -100000; minv = 100000;
        for (int c = 0; c < 530; c++) begin
            ce = (c < 512);
            @(negedge clk);
            if (out_valid) begin
                if (nv < 600) smp[nv] = sin_val[15:0];
                if (cnt_edge[0]) begin
                    if (first_edge < 0) first_edge = nv;
                    n_edge0++;
                end
                if (cnt_edge[1]) n_edge1++;
                if (int'($signed(sin_val[15:0])) > maxv) maxv = int'($signed(sin_val[15:0]));
                if (int'($signed(sin_val[15:0])) < minv) minv = int'($signed(sin_val[15:0]));
                nv++;
            end
        end
        ce = 1'b0;
        exp_cnt += 512;
        check("stream count", nv, 512);
        check("stream cnt", cnt, exp_cnt);
        check("stream s0", smp[0], 101);
        check("stream s64", smp[64], 32767);
        check("stream s128", smp[128], -101);
        check("stream s192", smp[192], -32767);
        check("stream s256", smp[256], 101);
        check("stream s320", smp[320], 32767);
        check("stream peak", maxv, 32767);
        check("stream trough", minv, -32767);
        check("stream wraps", n_edge0, 2);
        check("stream first wrap", first_edge, 255);
        check("stream ch1 wraps", n_edge1, 0);

        // Mid-stream reset with three samples in flight.
        cfg_write(0, 1, 32'h4000_0000);
        for (int i = 0; i < 3; i++) begin
            ce = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1; ce = 1'b0;
        @(negedge clk);
        check("midrst cnt", cnt, 0);
        check("midrst valid", out_valid, 0);
        reset = 1'b0;
        exp_cnt = 0;
        nvr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) nvr++;
        end
        check("midrst flushed", nvr, 0);
        expect_tick("restart", 0, 0, 0, 0, 101, 101, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ch0 samples for the config-timing sequence (freq 2^30, cleared at tick 5).
    localparam logic [15:0] ev_tbl [10] = '{
        16'd101, 16'd101, 16'd32767, 16'hFF9B, 16'h8001,
        16'd101, 16'd32767, 16'hFF9B, 16'h8001, 16'd101
    };

endmodule
